// File: rtl/hwpe_periph_initiator_if.sv
// HWPE peripheral bus between a bus master (initiator) and an accelerator slave port.
interface hwpe_periph_initiator_if #(
    parameter int unsigned ID = 10
);
    logic          req;
    logic          gnt;
    logic [31:0]   add;
    logic          wen;
    logic [3:0]    be;
    logic [31:0]   data;
    logic [ID-1:0] id;
    logic [31:0]   r_data;
    logic          r_valid;
    logic [ID-1:0] r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_data, r_valid, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_data, r_valid, r_id
    );
endinterface

// File: rtl/hwpe_periph_initiator.sv
// Single-outstanding HWPE peripheral bus master: turns valid/ready register commands into
// req/gnt + r_valid transactions, tags each with a rolling ID and aborts on timeout.
module hwpe_periph_initiator #(
    parameter int unsigned ID      = 10,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_wen_i,
    input  logic [31:0]             cmd_add_i,
    input  logic [31:0]             cmd_data_i,
    input  logic [3:0]              cmd_be_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [31:0]             rsp_data_o,
    output logic                    rsp_err_o,
    hwpe_periph_initiator_if.master periph,
    output logic                    busy_o,
    output logic                    id_mismatch_o
);

    localparam int unsigned     CntW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast   = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;
    localparam bit              TimeoutEn = (TIMEOUT != 0);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StRsp} state_e;

    state_e        r_state, w_state_d;
    logic [31:0]   r_add, r_data, r_rsp_data;
    logic          r_wen, r_rsp_err, r_mismatch;
    logic [3:0]    r_be;
    logic [ID-1:0] r_id, r_tag;
    logic [CntW-1:0] r_cnt;

    logic          w_accept, w_tag_inc, w_cnt_clr, w_rsp_load, w_rsp_err, w_mismatch_set;
    logic          w_cnt_last, w_id_match;
    logic [31:0]   w_rsp_data;

    assign w_cnt_last = TimeoutEn && (r_cnt == CntLast);
    assign w_id_match = (periph.r_id == r_id);

    // Next-state and per-cycle event decode
    always_comb begin
        w_state_d      = r_state;
        w_accept       = 1'b0;
        w_tag_inc      = 1'b0;
        w_cnt_clr      = 1'b0;
        w_rsp_load     = 1'b0;
        w_rsp_err      = 1'b0;
        w_rsp_data     = '0;
        w_mismatch_set = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_mismatch_set = periph.r_valid;
                if (cmd_valid_i) begin
                    w_accept  = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_state_d = StReq;
                end
            end
            StReq: begin
                // A response can never legally arrive before the cycle after gnt
                w_mismatch_set = periph.r_valid;
                if (periph.gnt) begin
                    w_tag_inc = 1'b1;
                    w_cnt_clr = 1'b1;
                    w_state_d = StWait;
                end else if (w_cnt_last) begin
                    // Tag still advances so the next transaction never reuses it
                    w_tag_inc  = 1'b1;
                    w_rsp_load = 1'b1;
                    w_rsp_err  = 1'b1;
                    w_state_d  = StRsp;
                end
            end
            StWait: begin
                if (periph.r_valid && w_id_match) begin
                    w_rsp_load = 1'b1;
                    w_rsp_data = r_wen ? periph.r_data : 32'h0;
                    w_state_d  = StRsp;
                end else begin
                    w_mismatch_set = periph.r_valid;
                    if (w_cnt_last) begin
                        w_rsp_load = 1'b1;
                        w_rsp_err  = 1'b1;
                        w_state_d  = StRsp;
                    end
                end
            end
            StRsp: begin
                w_mismatch_set = periph.r_valid;
                if (rsp_ready_i) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // FSM, timeout counter, tag counter, response and sticky mismatch registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_tag      <= '0;
            r_mismatch <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else if (clear_i) begin
            // Tag counter deliberately kept so a dropped transaction's tag is never reissued
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_mismatch <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (r_state == StReq || r_state == StWait) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_tag_inc) begin
                r_tag <= r_tag + 1'b1;
            end
            if (w_mismatch_set) begin
                r_mismatch <= 1'b1;
            end
            if (w_rsp_load) begin
                r_rsp_data <= w_rsp_data;
                r_rsp_err  <= w_rsp_err;
            end
        end
    end

    // Command capture; registered so there is no combinational path from cmd_* to periph_*
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_add  <= '0;
            r_wen  <= 1'b0;
            r_be   <= '0;
            r_data <= '0;
            r_id   <= '0;
        end else if (clear_i) begin
            r_add  <= '0;
            r_wen  <= 1'b0;
            r_be   <= '0;
            r_data <= '0;
            r_id   <= '0;
        end else if (w_accept) begin
            r_add  <= cmd_add_i;
            r_wen  <= cmd_wen_i;
            r_be   <= cmd_be_i;
            r_data <= cmd_data_i;
            r_id   <= r_tag;
        end
    end

    assign cmd_ready_o   = (r_state == StIdle);
    assign busy_o        = (r_state != StIdle);
    assign rsp_valid_o   = (r_state == StRsp);
    assign rsp_data_o    = r_rsp_data;
    assign rsp_err_o     = r_rsp_err;
    assign id_mismatch_o = r_mismatch;

    assign periph.req  = (r_state == StReq);
    assign periph.add  = r_add;
    assign periph.wen  = r_wen;
    assign periph.be   = r_be;
    assign periph.data = r_data;
    assign periph.id   = r_id;

endmodule

// File: tb/tb_hwpe_periph_initiator.sv
// Scoreboard bench: stimulus pushes expected responses, a slave model plays the accelerator,
// and a monitor pops and compares every response handshake.
module tb_hwpe_periph_initiator;

    localparam int unsigned ID      = 10;
    localparam int unsigned TIMEOUT = 8;

    typedef struct {
        logic        wen;
        logic [31:0] add;
        logic [31:0] data;
        logic [3:0]  be;
        int          gnt_dly;
        int          rsp_dly;
        bit          no_gnt;
        bit          no_rsp;
        bit          bad_id;
        bit          late;
        bit          cut;
        logic [ID-1:0] tag;
    } beh_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        mm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wen = 1'b0;
    logic [31:0] cmd_add = '0;
    logic [31:0] cmd_data = '0;
    logic [3:0]  cmd_be = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        id_mismatch;

    hwpe_periph_initiator_if #(.ID(ID)) periph_bus ();

    hwpe_periph_initiator #(.ID(ID), .TIMEOUT(TIMEOUT)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_wen_i     (cmd_wen),
        .cmd_add_i     (cmd_add),
        .cmd_data_i    (cmd_data),
        .cmd_be_i      (cmd_be),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_data_o    (rsp_data),
        .rsp_err_o     (rsp_err),
        .periph        (periph_bus),
        .busy_o        (busy),
        .id_mismatch_o (id_mismatch)
    );

    always #5 clk = ~clk;

    beh_t          beh_q[$];
    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [ID-1:0] exp_tag = '0;
    bit            mm_model = 1'b0;
    logic [31:0]   ref_mem[logic [31:0]];
    logic [31:0]   slave_mem[logic [31:0]];
    int            hold_req = 0;
    int            hold_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : 32'h0;
    endfunction

    // Reference model: expected response derived from the command and slave behaviour
    task automatic issue(input beh_t b);
        exp_t e;
        int   n;
        b.tag = exp_tag;
        if (!b.no_gnt && !b.wen) ref_mem[b.add] = merge(ref_rd(b.add), b.data, b.be);
        e.err  = b.no_gnt || b.no_rsp;
        e.data = (!e.err && b.wen) ? ref_rd(b.add) : 32'h0;
        if (b.bad_id) mm_model = 1'b1;
        e.mm = mm_model;
        beh_q.push_back(b);
        if (!b.cut) exp_q.push_back(e);
        if (b.late) mm_model = 1'b1;
        exp_tag = exp_tag + 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_wen   = b.wen;
        cmd_add   = b.add;
        cmd_data  = b.data;
        cmd_be    = b.be;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (cmd_ready !== 1'b1) fail("cmd_accept_timeout");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0 || beh_q.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) fail("idle_timeout");
    endtask

    // Accelerator slave model
    initial begin : slave
        beh_t b;
        int   n;
        periph_bus.gnt     = 1'b0;
        periph_bus.r_valid = 1'b0;
        periph_bus.r_id    = '0;
        periph_bus.r_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (periph_bus.req !== 1'b1) continue;
            if (beh_q.size() == 0) begin
                fail("unexpected_req");
                continue;
            end
            b = beh_q.pop_front();
            check("req_fields", {periph_bus.id, periph_bus.wen, periph_bus.be, periph_bus.add},
                  {b.tag, b.wen, b.be, b.add});
            check("req_data", periph_bus.data, b.data);
            if (b.no_gnt) begin
                n = 1;
                for (int k = 0; k < 40; k++) begin
                    @(posedge clk); #1;
                    if (periph_bus.req !== 1'b1) break;
                    n++;
                end
                if (!b.cut) check("req_timeout_len", 64'(n), 64'(TIMEOUT));
            end else begin
                for (int k = 0; k < b.gnt_dly; k++) begin
                    @(posedge clk); #1;
                    check("req_hold", {periph_bus.req, periph_bus.id, periph_bus.wen,
                          periph_bus.be, periph_bus.add}, {1'b1, b.tag, b.wen, b.be, b.add});
                    check("req_hold_data", periph_bus.data, b.data);
                end
                periph_bus.gnt = 1'b1;
                if (!b.wen) slave_mem[b.add] = merge(slave_rd(b.add), b.data, b.be);
                @(posedge clk); #1;
                periph_bus.gnt = 1'b0;
                check("req_drop_after_gnt", periph_bus.req, 1'b0);
                if (!b.no_rsp) begin
                    if (b.bad_id) begin
                        periph_bus.r_valid = 1'b1;
                        periph_bus.r_id    = b.tag ^ 10'h7;
                        periph_bus.r_data  = $urandom;
                        @(posedge clk); #1;
                        periph_bus.r_valid = 1'b0;
                    end
                    repeat (b.rsp_dly) begin
                        @(posedge clk); #1;
                    end
                    periph_bus.r_valid = 1'b1;
                    periph_bus.r_id    = b.tag;
                    periph_bus.r_data  = b.wen ? slave_rd(b.add) : $urandom;
                    @(posedge clk); #1;
                    periph_bus.r_valid = 1'b0;
                end else if (b.late) begin
                    n = 0;
                    while (busy !== 1'b0 && n < 60) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    periph_bus.r_valid = 1'b1;
                    periph_bus.r_id    = b.tag;
                    periph_bus.r_data  = $urandom;
                    @(posedge clk); #1;
                    periph_bus.r_valid = 1'b0;
                end
            end
        end
    end

    // Response consumer: random backpressure plus an optional forced hold
    initial begin : rsp_drv
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (hold_done < hold_req && rsp_valid === 1'b1) begin
                rsp_ready = 1'b0;
                hold_done++;
            end else begin
                rsp_ready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    // Monitor: compare each response handshake against the scoreboard
    initial begin : monitor
        exp_t        e;
        logic        held;
        logic [32:0] held_val;
        held = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
                check("rsp_phase_quiet", {cmd_ready, periph_bus.req}, 2'b00);
                if (held) check("rsp_stable", {rsp_err, rsp_data}, held_val);
                if (rsp_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        fail("rsp_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_err", rsp_err, e.err);
                        check("id_mismatch", id_mismatch, e.mm);
                    end
                    held = 1'b0;
                end else begin
                    held     = 1'b1;
                    held_val = {rsp_err, rsp_data};
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin : stim
        beh_t b;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", periph_bus.req, 1'b0);
        check("rst_status", {rsp_valid, rsp_err, busy, id_mismatch}, 4'b0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_bus", {periph_bus.id, periph_bus.wen, periph_bus.be, periph_bus.add}, '0);
        check("rst_bus_data", periph_bus.data, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("cmd_ready_after_rst", cmd_ready, 1'b1);

        // Write, gnt with req, r_valid the cycle after
        b = '{default: '0};
        b.add = 32'h20; b.data = 32'hDEADBEEF; b.be = 4'hF;
        issue(b); wait_idle();

        b = '{default: '0};
        b.add = 32'h0C; b.data = 32'h0000_1234; b.be = 4'hF; b.rsp_dly = 2;
        issue(b); wait_idle();

        // Read with gnt delayed 3 cycles
        b = '{default: '0};
        b.wen = 1'b1; b.add = 32'h0C; b.gnt_dly = 3;
        issue(b); wait_idle();

        // Grant never comes
        b = '{default: '0};
        b.wen = 1'b1; b.add = 32'h10; b.no_gnt = 1'b1;
        issue(b); wait_idle();
        check("busy_after_abort", busy, 1'b0);

        // Response never comes, then arrives late
        b = '{default: '0};
        b.wen = 1'b1; b.add = 32'h0C; b.no_rsp = 1'b1; b.late = 1'b1;
        issue(b); wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("late_rsp_mismatch", id_mismatch, 1'b1);

        // Clear while waiting for the response
        b = '{default: '0};
        b.wen = 1'b1; b.add = 32'h20; b.no_rsp = 1'b1; b.cut = 1'b1;
        issue(b);
        @(posedge clk); #2;
        check("wait_before_clear", {busy, periph_bus.req}, 2'b10);
        clear = 1'b1;
        @(posedge clk); #2;
        clear = 1'b0;
        check("clear_status", {busy, periph_bus.req, rsp_valid, id_mismatch}, 4'b0);
        mm_model = 1'b0;

        // Wrong-ID response before the right one
        b = '{default: '0};
        b.add = 32'h40; b.data = 32'h0000_00A5; b.be = 4'hF;
        issue(b); wait_idle();
        b = '{default: '0};
        b.wen = 1'b1; b.add = 32'h40; b.bad_id = 1'b1; b.rsp_dly = 1;
        issue(b); wait_idle();

        // Response held off for 5 cycles
        hold_req = 5;
        b = '{default: '0};
        b.wen = 1'b1; b.add = 32'h20;
        issue(b); wait_idle();
        check("rsp_hold_applied", 64'(hold_done), 64'd5);

        // Asynchronous reset while requesting
        b = '{default: '0};
        b.wen = 1'b1; b.add = 32'h44; b.no_gnt = 1'b1; b.cut = 1'b1;
        issue(b);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_status", {periph_bus.req, busy, rsp_valid, id_mismatch}, 4'b0);
        check("rst_async_bus", {periph_bus.wen, periph_bus.be, periph_bus.add}, '0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        exp_tag  = '0;
        mm_model = 1'b0;

        for (int i = 0; i < 60; i++) begin
            b = '{default: '0};
            b.wen     = 1'($urandom_range(0, 1));
            b.add     = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
            b.data    = $urandom;
            b.be      = 4'($urandom_range(1, 15));
            b.gnt_dly = $urandom_range(0, 3);
            b.rsp_dly = $urandom_range(0, 3);
            b.no_gnt  = ($urandom_range(0, 9) == 0);
            b.no_rsp  = !b.no_gnt && ($urandom_range(0, 9) == 0);
            b.bad_id  = !b.no_gnt && !b.no_rsp && ($urandom_range(0, 7) == 0);
            issue(b);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
